polar_psum_encoder: RTL
=======================

// Module: polar_psum_encoder
// PURPOSE
// - Builds the partial-sum (u) vector for a row of g stages in the SC polar decoder.
// - Collects N hard-decided bits from the left subtree, one per handshake.
// - Re-encodes them with the polar transform x = u*F^(xn), F=[[1,0],[1,1]], natural order, no bit reversal.
// - Presents x as psum[N-1:0]; bit j drives the u input of g instance j.
// PARAMETERS
// - N      8   Frame length in bits; power of two, N >= 2.
// - LOG2N  3   log2(N); must equal $clog2(N). Gives the stage count and counter width.
// PORTS
// - clk         in   1          Rising-edge clock.
// - rst         in   1          Synchronous reset, active-high.
// - bit_in      in   1          Decided bit; the k-th accepted bit is u[k].
// - bit_valid   in   1          bit_in is valid.
// - bit_ready   out  1          Block can accept a bit.
// - psum        out  N          Encoded partial-sum vector; bit j = x_j.
// - psum_valid  out  1          psum holds a complete frame.
// - psum_ready  in   1          Consumer takes psum.
// BEHAVIOUR
// - One clock domain. Reset is synchronous, active-high; all state updates on the rising edge of clk.
// - Reset values: state=COLLECT, cnt=0, vector v=0, bit_ready=1, psum_valid=0, psum=0.
// - psum is driven directly from the v register. It is only meaningful while psum_valid=1.
// - FSM states:
//   - COLLECT: bit_ready=1.
//     - On bit_valid=1: v[cnt] <= bit_in, cnt++.
//     - When the bit with cnt=N-1 is accepted: cnt <= 0, go to ENCODE.
//   - ENCODE: bit_ready=0, psum_valid=0.
//     - Stage counter s runs 0..LOG2N-1, one stage per cycle.
//     - Per stage, for every j with bit s clear: v[j] <= v[j] ^ v[j | (1<<s)]. All other bits hold.
//     - After stage LOG2N-1: go to OUTPUT.
//   - OUTPUT: psum_valid=1 and v is held stable.
//     - On psum_ready=1: go to COLLECT, v <= 0.
//     - bit_ready goes high the next cycle.
// - Result: x_j = XOR of u_i over every i whose bit set contains j's ((i & j) == j).
// - Latency:
//   - Last bit accepted at edge t; psum_valid is high from cycle t+LOG2N+1.
//   - Minimum frame period is N+LOG2N+1 cycles.
// - Handshakes: a transfer occurs only when valid and ready are both high at an edge.
//   - bit_valid while bit_ready=0 is ignored. No bit is buffered or dropped into the next frame.
//   - psum_ready while psum_valid=0 has no effect.
// - Backpressure: OUTPUT holds indefinitely. psum and psum_valid stay constant until psum_ready.
// - Simultaneous events: rst has priority over every handshake and FSM transition.
// - Reset mid-frame (COLLECT, ENCODE or OUTPUT) discards the partial frame and returns to the reset values next cycle.
// - Counter wrap: cnt wraps N-1 -> 0 only on the frame's last accepted bit. No overflow path exists.
// - Arithmetic is GF(2), XOR only. There is no soft or signed data.
// TESTING
// - N=8, bits u0..u7 = 1,0,0,0,0,0,0,0 -> psum=8'h01; psum_valid rises 4 cycles after the last accept.
// - N=8, u7=1 only -> psum=8'hFF. N=8, all ones -> psum=8'h80.
//   N=8, u=1,1,0,0,0,0,0,0 -> psum=8'h02.
// - Gapped bit_valid (toggling every cycle) -> same psum as back-to-back input.
//   bit_ready stays low throughout ENCODE and OUTPUT.
// - psum_ready held low 10 cycles -> psum and psum_valid are stable. Release -> bit_ready=1 next cycle.
//   The next frame then encodes independently (no carry-over from v).
// - rst asserted after 5 accepted bits, and again during ENCODE -> outputs return to reset values.
//   A following full frame u7=1 yields psum=8'hFF.
// - Random frames, N=4/8/16 -> psum matches a reference model x_j = XOR of u_i over i with (i&j)==j.

Source files
------------

// File: rtl/polar_psum_encoder_if.sv
// Handshake bundle for the polar partial-sum encoder: a bit stream in, one encoded frame out.
interface polar_psum_encoder_if #(
  parameter int N = 8
) ();
  logic         bit_in;
  logic         bit_valid;
  logic         bit_ready;
  logic [N-1:0] psum;
  logic         psum_valid;
  logic         psum_ready;

  modport master (
    output bit_in, bit_valid, psum_ready,
    input  bit_ready, psum, psum_valid
  );

  modport slave (
    input  bit_in, bit_valid, psum_ready,
    output bit_ready, psum, psum_valid
  );
endinterface

// File: rtl/polar_psum_encoder.sv
// Collects N decided bits, applies the polar transform in place one butterfly stage
// per cycle, then holds the encoded partial-sum vector until the consumer takes it.
module polar_psum_encoder #(
  parameter int N     = 8,
  parameter int LOG2N = 3
) (
  input  logic                clk,
  input  logic                rst,
  polar_psum_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    COLLECT,
    ENCODE,
    OUTPUT
  } state_t;

  localparam logic [LOG2N-1:0] LAST_CNT = {LOG2N{1'b1}};

  state_t           r_state;
  logic [LOG2N-1:0] r_cnt;
  logic [LOG2N-1:0] r_stage;
  logic [N-1:0]     r_v;
  logic             r_bitReady;
  logic             r_psumValid;
  logic [N-1:0]     w_stageV;

  // One butterfly stage: each bit with stage bit s clear absorbs its partner at j|(1<<s).
  always_comb begin
    w_stageV = r_v;
    for (int s = 0; s < LOG2N; s++) begin
      if (int'(r_stage) == s) begin
        for (int j = 0; j < N; j++) begin
          if (((j >> s) & 1) == 0) begin
            w_stageV[j] = r_v[j] ^ r_v[j | (1 << s)];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= COLLECT;
      r_cnt       <= '0;
      r_stage     <= '0;
      r_v         <= '0;
      r_bitReady  <= 1'b1;
      r_psumValid <= 1'b0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (bus.bit_valid) begin
            r_v[r_cnt] <= bus.bit_in;
            r_cnt      <= r_cnt + 1'b1;
            if (r_cnt == LAST_CNT) begin
              r_state    <= ENCODE;
              r_stage    <= '0;
              r_bitReady <= 1'b0;
            end
          end
        end
        ENCODE: begin
          r_v     <= w_stageV;
          r_stage <= r_stage + 1'b1;
          if (int'(r_stage) == LOG2N - 1) begin
            r_state     <= OUTPUT;
            r_stage     <= '0;
            r_psumValid <= 1'b1;
          end
        end
        OUTPUT: begin
          if (bus.psum_ready) begin
            r_state     <= COLLECT;
            r_v         <= '0;
            r_psumValid <= 1'b0;
            r_bitReady  <= 1'b1;
          end
        end
        default: begin
          r_state     <= COLLECT;
          r_cnt       <= '0;
          r_stage     <= '0;
          r_v         <= '0;
          r_bitReady  <= 1'b1;
          r_psumValid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.psum       = r_v;
  assign bus.bit_ready  = r_bitReady;
  assign bus.psum_valid = r_psumValid;

endmodule
